// File: rtl/frame_arb_pkg.sv
// Shared types and helpers for the frame round-robin arbiter.
package frame_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Index width for a range of n items, never narrower than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_arb_rr_pick.sv
// Round-robin picker: first requesting index at or above rr_ptr_i, wrapping
// back through index 0.
module frame_arb_rr_pick
    import frame_arb_pkg::*;
#(
    parameter int NUM_SRCS = 4,
    parameter int SRC_W    = safe_clog2(NUM_SRCS)
) (
    input  logic [NUM_SRCS-1:0] req_i,
    input  logic [SRC_W-1:0]    rr_ptr_i,
    output logic                valid_o,
    output logic [SRC_W-1:0]    idx_o
);

    int               cand_s;
    logic [SRC_W-1:0] cand_idx_s;
    logic             found_s;

    // Priority scan over the rotated request vector.
    always_comb begin
        found_s    = 1'b0;
        idx_o      = '0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 0; k < NUM_SRCS; k++) begin
            cand_s     = int'(rr_ptr_i) + k;
            cand_idx_s = SRC_W'((cand_s >= NUM_SRCS) ? (cand_s - NUM_SRCS) : cand_s);
            if (!found_s && req_i[cand_idx_s]) begin
                found_s = 1'b1;
                idx_o   = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin arbiter: merges NUM_SRCS framed streams onto one
// destination, holding the grant from startframe through endframe.
module frame_rr_arbiter
    import frame_arb_pkg::*;
#(
    parameter int NUM_SRCS   = 4,
    parameter int DATA_W     = 512,
    parameter int PADBYTES_W = safe_clog2(DATA_W / 8),
    parameter int SRC_W      = safe_clog2(NUM_SRCS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRCS-1:0]            src_arb_val,
    input  logic [NUM_SRCS-1:0]            src_arb_startframe,
    input  logic [NUM_SRCS-1:0]            src_arb_endframe,
    input  logic [NUM_SRCS*DATA_W-1:0]     src_arb_data,
    input  logic [NUM_SRCS*PADBYTES_W-1:0] src_arb_padbytes,
    output logic [NUM_SRCS-1:0]            arb_src_rdy,
    output logic                           arb_dst_val,
    output logic                           arb_dst_startframe,
    output logic                           arb_dst_endframe,
    output logic [DATA_W-1:0]              arb_dst_data,
    output logic [PADBYTES_W-1:0]          arb_dst_padbytes,
    input  logic                           dst_arb_rdy,
    output logic [SRC_W-1:0]               arb_grant_idx,
    output logic                           arb_busy,
    output logic                           arb_proto_err
);

    arb_state_e            state_q, state_d;
    logic [SRC_W-1:0]      grant_q, grant_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  err_q, err_d;
    logic                  pick_valid_s;
    logic [SRC_W-1:0]      pick_idx_s;
    logic                  g_val_s, g_sof_s, g_eof_s, xfer_s;
    logic [DATA_W-1:0]     g_data_s;
    logic [PADBYTES_W-1:0] g_pad_s;

    frame_arb_rr_pick #(
        .NUM_SRCS (NUM_SRCS),
        .SRC_W    (SRC_W)
    ) u_pick (
        .req_i    (src_arb_val),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid_s),
        .idx_o    (pick_idx_s)
    );

    // Select the granted source's lane; the payload path has no register stage.
    always_comb begin
        g_val_s  = src_arb_val[grant_q];
        g_sof_s  = src_arb_startframe[grant_q];
        g_eof_s  = src_arb_endframe[grant_q];
        g_data_s = src_arb_data[int'(grant_q) * DATA_W +: DATA_W];
        g_pad_s  = src_arb_padbytes[int'(grant_q) * PADBYTES_W +: PADBYTES_W];
        xfer_s   = g_val_s & dst_arb_rdy;
    end

    // Next-state, pointer/error update and merged-stream outputs.
    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        rr_ptr_d           = rr_ptr_q;
        err_d              = err_q;
        arb_src_rdy        = '0;
        arb_dst_val        = 1'b0;
        arb_dst_startframe = 1'b0;
        arb_dst_endframe   = 1'b0;
        arb_dst_data       = '0;
        arb_dst_padbytes   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_idx_s;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT, LOCKED: begin
                arb_dst_val          = g_val_s;
                arb_dst_startframe   = g_sof_s;
                arb_dst_endframe     = g_eof_s;
                arb_dst_data         = g_data_s;
                arb_dst_padbytes     = g_pad_s;
                arb_src_rdy[grant_q] = dst_arb_rdy;
                if (xfer_s) begin
                    // First beat must carry startframe; later beats must not.
                    if (((state_q == GRANT) && !g_sof_s) || ((state_q == LOCKED) && g_sof_s)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (g_eof_s) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == SRC_W'(NUM_SRCS - 1)) ? '0 : grant_q + SRC_W'(1);
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign arb_grant_idx = grant_q;
    assign arb_busy      = (state_q == LOCKED);
    assign arb_proto_err = err_q;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Bench for frame_rr_arbiter: per-source beat queues drive the inputs and a
// frame-level round-robin model predicts every cycle's outputs.
module tb_frame_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 2;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        logic          s;
        logic          e;
    } beat_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    val, sof, eof;
    logic [N*DW-1:0] data;
    logic [N*PW-1:0] pad;
    logic [N-1:0]    rdy;
    logic            dval, dsof, deof, dst_rdy, busy, perr;
    logic [DW-1:0]   ddata;
    logic [PW-1:0]   dpad;
    logic [SW-1:0]   gidx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    beat_t         srcq     [N][$];
    logic [DW-1:0] exp_data [N][$];
    logic [DW-1:0] obs_data [N][$];
    int            obs_frames[$];
    int            obs_sof_cyc[$];
    int            obs_eof_cyc[$];
    int            rdy0_stray, busy_seen;

    // Model: owner is -1 while nobody holds the output.
    int m_owner, m_beats, m_ptr, m_grant;
    bit m_err;
    int val_pct, rdy_mode, xfer_src;
    bit tog;

    always #5 clk = ~clk;

    frame_rr_arbiter #(.NUM_SRCS(N), .DATA_W(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .src_arb_val        (val),
        .src_arb_startframe (sof),
        .src_arb_endframe   (eof),
        .src_arb_data       (data),
        .src_arb_padbytes   (pad),
        .arb_src_rdy        (rdy),
        .arb_dst_val        (dval),
        .arb_dst_startframe (dsof),
        .arb_dst_endframe   (deof),
        .arb_dst_data       (ddata),
        .arb_dst_padbytes   (dpad),
        .dst_arb_rdy        (dst_rdy),
        .arb_grant_idx      (gidx),
        .arb_busy           (busy),
        .arb_proto_err      (perr)
    );

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N; i++) n += srcq[i].size();
        return n;
    endfunction

    function automatic bit same_list(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit data_ok(input int s);
        if (exp_data[s].size() != obs_data[s].size()) return 1'b0;
        for (int i = 0; i < exp_data[s].size(); i++)
            if (exp_data[s][i] !== obs_data[s][i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < N; i++) begin
            exp_data[i].delete();
            obs_data[i].delete();
        end
        obs_frames.delete();
        obs_sof_cyc.delete();
        obs_eof_cyc.delete();
        rdy0_stray = 0;
        busy_seen  = 0;
    endtask

    task automatic add_frame(input int s, input int len, input int bad_sof_at = -1);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.p = PW'($urandom);
            b.s = (i == 0) || (i == bad_sof_at);
            b.e = (i == len - 1);
            srcq[s].push_back(b);
            exp_data[s].push_back(b.d);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                val[i]            = ($urandom_range(99) < val_pct);
                sof[i]            = srcq[i][0].s;
                eof[i]            = srcq[i][0].e;
                data[i*DW +: DW]  = srcq[i][0].d;
                pad[i*PW +: PW]   = srcq[i][0].p;
            end else begin
                val[i]            = 1'b0;
                sof[i]            = 1'($urandom_range(1));
                eof[i]            = 1'($urandom_range(1));
                data[i*DW +: DW]  = $urandom;
                pad[i*PW +: PW]   = PW'($urandom);
            end
        end
        case (rdy_mode)
            0: dst_rdy = 1'b1;
            1: begin
                dst_rdy = tog;
                tog     = ~tog;
            end
            default: dst_rdy = 1'($urandom_range(1));
        endcase
    endtask

    // One clock: check outputs at negedge against the model, then advance.
    task automatic cycle();
        logic [N-1:0] e_rdy;
        logic         e_val, e_busy;
        int           c;
        @(negedge clk);
        e_rdy  = '0;
        e_val  = 1'b0;
        e_busy = 1'b0;
        if (m_owner >= 0) begin
            e_val          = val[m_owner];
            e_rdy[m_owner] = dst_rdy;
            e_busy         = (m_beats > 0);
        end
        checks++;
        if (dval !== e_val || rdy !== e_rdy || busy !== e_busy || gidx !== SW'(m_grant) || perr !== m_err) begin
            errors++;
            $display("FAIL ctrl cyc=%0d got val=%b rdy=%b busy=%b gidx=%0d err=%b want val=%b rdy=%b busy=%b gidx=%0d err=%b",
                     cyc, dval, rdy, busy, gidx, perr, e_val, e_rdy, e_busy, m_grant, m_err);
        end
        if (e_val) begin
            checks++;
            if ({dsof, deof, ddata, dpad} !== {sof[m_owner], eof[m_owner], data[m_owner*DW +: DW], pad[m_owner*PW +: PW]}) begin
                errors++;
                $display("FAIL payload cyc=%0d got sof=%b eof=%b data=%h pad=%h want sof=%b eof=%b data=%h pad=%h",
                         cyc, dsof, deof, ddata, dpad, sof[m_owner], eof[m_owner],
                         data[m_owner*DW +: DW], pad[m_owner*PW +: PW]);
            end
        end
        if (dval && dst_rdy) begin
            obs_data[gidx].push_back(ddata);
            if (dsof) obs_sof_cyc.push_back(cyc);
            if (deof) begin
                obs_eof_cyc.push_back(cyc);
                obs_frames.push_back(int'(gidx));
            end
        end
        if (rdy[0] && gidx != SW'(0)) rdy0_stray++;
        if (busy) busy_seen++;
        xfer_src = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (m_owner < 0 && val[c]) begin
                    m_owner = c;
                    m_grant = c;
                    m_beats = 0;
                end
            end
        end else if (val[m_owner] && dst_rdy) begin
            xfer_src = m_owner;
            if ((m_beats == 0 && !sof[m_owner]) || (m_beats > 0 && sof[m_owner])) m_err = 1'b1;
            if (eof[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_beats++;
            end
        end
        @(posedge clk);
        #1;
        if (xfer_src >= 0) void'(srcq[xfer_src].pop_front());
        drive();
        cyc++;
    endtask

    task automatic run_idle(input int max_cyc);
        int n = 0;
        while (n < max_cyc && (m_owner >= 0 || pending() > 0)) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL timeout got %0d cycles with %0d beats pending, want drain within %0d", n, pending(), max_cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        m_grant = 0;
        m_err   = 1'b0;
        drive();
        #2;
        checks++;
        if (dval !== 1'b0 || rdy !== '0 || busy !== 1'b0 || gidx !== '0 || perr !== 1'b0) begin
            errors++;
            $display("FAIL reset got val=%b rdy=%b busy=%b gidx=%0d err=%b want all zero", dval, rdy, busy, gidx, perr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        val_pct  = 100;
        rdy_mode = 0;
        do_reset();
        cycle();
    endtask

    task automatic test_three_beat();
        int want[$];
        clear_logs();
        add_frame(1, 3);
        drive();
        run_idle(50);
        want = '{1};
        checks++;
        if (!same_list(obs_frames, want) || !data_ok(1)) begin
            errors++;
            $display("FAIL three_beat got frames=%0d beats=%0d want frames=1 from src1 beats=3", obs_frames.size(), obs_data[1].size());
        end
        checks++;
        if (obs_sof_cyc.size() != 1 || obs_eof_cyc.size() != 1 || obs_eof_cyc[0] - obs_sof_cyc[0] != 2) begin
            errors++;
            $display("FAIL three_beat_span got sof/eof markers %0d/%0d want one each two cycles apart", obs_sof_cyc.size(), obs_eof_cyc.size());
        end
        clear_logs();
        add_frame(0, 2);
        add_frame(2, 2);
        drive();
        run_idle(50);
        want = '{2, 0};
        checks++;
        if (!same_list(obs_frames, want)) begin
            errors++;
            $display("FAIL ptr_after_src1 got first=%0d want order 2,0", obs_frames.size() > 0 ? obs_frames[0] : -1);
        end
    endtask

    task automatic test_rotation();
        int want[$];
        int bad_gap = 0;
        do_reset();
        clear_logs();
        add_frame(0, 2);
        add_frame(1, 2);
        add_frame(2, 2);
        add_frame(3, 2);
        add_frame(0, 2);
        drive();
        run_idle(100);
        want = '{0, 1, 2, 3, 0};
        checks++;
        if (!same_list(obs_frames, want)) begin
            errors++;
            $display("FAIL rotation got %0d frames first=%0d want order 0,1,2,3,0", obs_frames.size(), obs_frames.size() > 0 ? obs_frames[0] : -1);
        end
        for (int k = 0; k + 1 < obs_sof_cyc.size() && k < obs_eof_cyc.size(); k++)
            if (obs_sof_cyc[k+1] - obs_eof_cyc[k] != 2) bad_gap++;
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL idle_gap got %0d gaps not equal to one idle cycle want 0", bad_gap);
        end
        checks++;
        if (!data_ok(0) || !data_ok(1) || !data_ok(2) || !data_ok(3)) begin
            errors++;
            $display("FAIL rotation_data got beat lists differing from sources want exact order");
        end
    endtask

    task automatic test_lock();
        int want[$];
        clear_logs();
        add_frame(2, 4);
        drive();
        for (int i = 0; i < 10 && m_beats < 1; i++) cycle();
        add_frame(0, 2);
        run_idle(60);
        want = '{2, 0};
        checks++;
        if (!same_list(obs_frames, want) || rdy0_stray != 0) begin
            errors++;
            $display("FAIL lock got frames=%0d stray_rdy0=%0d want order 2,0 and no early rdy0", obs_frames.size(), rdy0_stray);
        end
    endtask

    task automatic test_backpressure();
        int want[$];
        clear_logs();
        rdy_mode = 1;
        tog      = 1'b1;
        add_frame(1, 4);
        drive();
        run_idle(60);
        want = '{1};
        checks++;
        if (!same_list(obs_frames, want) || !data_ok(1)) begin
            errors++;
            $display("FAIL backpressure got %0d beats want 4 beats in source order", obs_data[1].size());
        end
        rdy_mode = 0;
    endtask

    task automatic test_proto_err();
        do_reset();
        clear_logs();
        add_frame(3, 1);
        drive();
        run_idle(30);
        checks++;
        if (perr !== 1'b0 || busy_seen != 0 || obs_frames.size() != 1) begin
            errors++;
            $display("FAIL single_beat got err=%b busy_cycles=%0d frames=%0d want 0,0,1", perr, busy_seen, obs_frames.size());
        end
        add_frame(0, 3, 1);
        drive();
        run_idle(30);
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL proto_err_set got %b want 1", perr);
        end
        add_frame(1, 2);
        drive();
        run_idle(30);
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL proto_err_sticky got %b want 1", perr);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_frame();
        int want[$];
        clear_logs();
        add_frame(2, 1);
        drive();
        run_idle(30);
        add_frame(1, 4);
        drive();
        for (int i = 0; i < 10 && m_beats < 1; i++) cycle();
        do_reset();
        clear_logs();
        cycle();
        add_frame(1, 2);
        add_frame(3, 2);
        drive();
        run_idle(60);
        want = '{1, 3};
        checks++;
        if (!same_list(obs_frames, want) || !data_ok(1)) begin
            errors++;
            $display("FAIL reset_mid got %0d frames src1 beats=%0d want order 1,3 with 2 fresh beats", obs_frames.size(), obs_data[1].size());
        end
    endtask

    task automatic test_random();
        clear_logs();
        val_pct  = 70;
        rdy_mode = 2;
        for (int f = 0; f < 3; f++)
            for (int s = 0; s < N; s++) add_frame(s, 1 + int'($urandom_range(3)));
        drive();
        run_idle(2000);
        for (int s = 0; s < N; s++) begin
            checks++;
            if (!data_ok(s)) begin
                errors++;
                $display("FAIL random_src%0d got %0d beats want %0d in order", s, obs_data[s].size(), exp_data[s].size());
            end
        end
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL random_err got %b want 0", perr);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_three_beat();
        test_rotation();
        test_lock();
        test_backpressure();
        test_proto_err();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_rr_arbiter.md
FRAME_RR_ARBITER -- requirements
Module: frame_rr_arbiter

Interface
REQ-001 Parameter NUM_SRCS, default 4, meaning number of requesting streams (2..16).
REQ-002 Parameter DATA_W, default 512, meaning data width in bits.
REQ-003 Parameter PADBYTES_W, default BSG_SAFE_CLOG2(DATA_W/8), meaning padbytes field width.
REQ-004 Parameter SRC_W, default BSG_SAFE_CLOG2(NUM_SRCS), meaning grant index width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 src_arb_val  input  NUM_SRCS  per-source beat valid.
REQ-008 src_arb_startframe  input  NUM_SRCS  per-source first-beat flag.
REQ-009 src_arb_endframe  input  NUM_SRCS  per-source last-beat flag.
REQ-010 src_arb_data  input  NUM_SRCS*DATA_W  per-source data, source i at bits [i*DATA_W +: DATA_W].
REQ-011 src_arb_padbytes  input  NUM_SRCS*PADBYTES_W  per-source padbytes, same packing.
REQ-012 arb_src_rdy  output  NUM_SRCS  per-source ready.
REQ-013 arb_dst_val, arb_dst_startframe, arb_dst_endframe  output  1 each  merged stream control.
REQ-014 arb_dst_data  output  DATA_W; arb_dst_padbytes  output  PADBYTES_W; merged payload.
REQ-015 dst_arb_rdy  input  1  downstream ready.
REQ-016 arb_grant_idx  output  SRC_W  currently granted source; arb_busy  output  1  high in LOCKED.
REQ-017 arb_proto_err  output  1  sticky protocol-error flag.

Function
REQ-018 Beat transfers on a port when val & rdy are both high in the same cycle.
REQ-019 States: IDLE, GRANT, LOCKED.
REQ-020 IDLE: all arb_src_rdy low, arb_dst_val low; when any src_arb_val high, pick first valid index scanning upward from rr_ptr with wrap, register grant_idx, go GRANT.
REQ-021 GRANT and LOCKED: arb_dst_val/startframe/endframe/data/padbytes = granted source's inputs; arb_src_rdy[grant_idx] = dst_arb_rdy; all other ready bits low.
REQ-022 GRANT: on transfer with endframe high -> IDLE; on transfer with endframe low -> LOCKED; otherwise stay.
REQ-023 LOCKED: on transfer with endframe high -> IDLE; else stay; no re-arbitration mid-frame.
REQ-024 On each transfer with endframe high, rr_ptr <= grant_idx+1, wrapping NUM_SRCS-1 -> 0.
REQ-025 Latency: one idle cycle between a frame's end and the next grant; data path combinational, zero added latency.
REQ-026 Transfer in GRANT with startframe low, or in LOCKED with startframe high, sets arb_proto_err; beat is still forwarded.
REQ-027 A source deasserting val mid-frame holds the grant; arbiter waits indefinitely.
REQ-028 Single-beat frame (startframe & endframe) completes in GRANT and returns to IDLE.
REQ-029 Requests arriving while LOCKED are served only after the current endframe.
REQ-030 arb_grant_idx reflects registered grant_idx in all states; arb_busy high only in LOCKED.

Reset
REQ-031 rst_n low asynchronously forces IDLE, rr_ptr=0, grant_idx=0, arb_proto_err=0; outputs arb_dst_val=0, arb_src_rdy=0, arb_busy=0.
REQ-032 Reset mid-frame abandons the frame; no completion beat is emitted.
REQ-033 After rst_n deasserts, first arbitration starts from index 0.

Structure
REQ-034 State enum (IDLE, GRANT, LOCKED) lives in shared package frame_arb_pkg.
REQ-035 Round-robin picker is sub-module frame_arb_rr_pick (inputs req vector and rr_ptr; outputs valid and index).

Verification
REQ-036 NUM_SRCS=4, src1 sends 3-beat frame, dst_rdy=1 -> arb_dst sees 3 beats with startframe on beat0, endframe on beat2, grant_idx=1, rr_ptr then 2.
REQ-037 src0..3 all valid with 2-beat frames from reset -> output frame order 0,1,2,3,0, one idle cycle between frames.
REQ-038 src2 mid-frame, src0 asserts val -> src0 rdy stays low until src2 endframe accepted, then src0 granted.
REQ-039 dst_arb_rdy toggling 1,0,1,0 during a 4-beat frame -> no beat duplicated or lost, data matches source order.
REQ-040 src3 single-beat frame followed by LOCKED beat with startframe=1 on src0 -> arb_proto_err=1 and stays 1 until reset.
REQ-041 rst_n asserted in LOCKED after beat 1 of 4 -> next cycle arb_dst_val=0, all rdy=0; after release, arbitration from index 0.
